// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: instruction word width, the NOP encoding
// and the fetch response record handed from instruction memory to decode.
package mips_pkg;

    localparam int WORD_W = 32;
    localparam int PC_W   = 32;

    localparam logic [WORD_W-1:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [PC_W-1:0]   addr;
        logic [WORD_W-1:0] instr;
        logic              err;
    } fetch_rsp_t;

endpackage

// File: rtl/imem_rsp_fifo.sv
// Synchronous FIFO with simultaneous push/pop at any fill level. The depth
// need not be a power of two, so both pointers wrap explicitly.
module imem_rsp_fifo
    import mips_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] store [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign do_push = push && (!full || do_pop);
    assign head    = store[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) store[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts fetch addresses, reads the word array
// and returns {addr, instr, err} LATENCY cycles later through a response FIFO.
module imem_responder
    import mips_pkg::*;
#(
    parameter int                ADDR_W   = PC_W,
    parameter int                DEPTH    = 256,
    parameter int                LATENCY  = 2,
    parameter logic [WORD_W-1:0] NOP_WORD = NOP_INSTR
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ADDR_W-1:0]        req_addr,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WORD_W-1:0]        rsp_instr,
    output logic [ADDR_W-1:0]        rsp_addr,
    output logic                     rsp_err,
    input  logic                     ld_we,
    input  logic [$clog2(DEPTH)-1:0] ld_addr,
    input  logic [WORD_W-1:0]        ld_data
);

    localparam int IDX_W   = $clog2(DEPTH);
    localparam int FIFO_D  = LATENCY + 1;
    localparam int ENTRY_W = ADDR_W + WORD_W + 1;
    localparam int CNT_W   = $clog2(FIFO_D + 1);
    localparam int OCC_W   = CNT_W + 1;

    logic [WORD_W-1:0]  mem [DEPTH];
    logic [ADDR_W-3:0]  word_idx;
    logic               addr_err;
    logic               accept;
    logic               pop;

    logic [LATENCY-1:0] vld_p;
    logic [ADDR_W-1:0]  addr_p  [LATENCY];
    logic [WORD_W-1:0]  instr_p [LATENCY];
    logic               err_p   [LATENCY];

    logic [ENTRY_W-1:0] fifo_head;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic [OCC_W-1:0]   occupancy;

    assign word_idx = req_addr[ADDR_W-1:2];
    assign addr_err = (req_addr[1:0] != 2'b00) || (word_idx >= (ADDR_W-2)'(DEPTH));

    always_ff @(posedge CLK) begin
        if (ld_we) mem[ld_addr] <= ld_data;
    end

    // Every accepted request holds a slot until it is popped, so counting the
    // pipeline together with the FIFO guarantees the FIFO can never overflow.
    always_comb begin
        occupancy = OCC_W'(fifo_count);
        for (int i = 0; i < LATENCY; i++) begin
            occupancy = occupancy + OCC_W'(vld_p[i]);
        end
    end

    assign pop       = rsp_valid && rsp_ready;
    assign req_ready = !RESET &&
                       ((occupancy < OCC_W'(FIFO_D)) || ((occupancy == OCC_W'(FIFO_D)) && pop));
    assign accept    = req_valid && req_ready;

    // Stage 0: the array is read at the accept edge; a same-edge load write
    // lands after the read, so the fetch sees the old word.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            vld_p <= '0;
        end else begin
            vld_p[0] <= accept;
            for (int i = 1; i < LATENCY; i++) begin
                vld_p[i] <= vld_p[i-1];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (accept) begin
            addr_p[0]  <= req_addr;
            err_p[0]   <= addr_err;
            instr_p[0] <= addr_err ? NOP_WORD : mem[word_idx[IDX_W-1:0]];
        end
        for (int i = 1; i < LATENCY; i++) begin
            addr_p[i]  <= addr_p[i-1];
            err_p[i]   <= err_p[i-1];
            instr_p[i] <= instr_p[i-1];
        end
    end

    // Final stage: the last pipeline entry is pushed into the response FIFO.
    imem_rsp_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_D),
        .CNT_W (CNT_W)
    ) u_rsp_fifo (
        .clk       (CLK),
        .rst       (RESET),
        .push      (vld_p[LATENCY-1]),
        .push_data ({addr_p[LATENCY-1], instr_p[LATENCY-1], err_p[LATENCY-1]}),
        .pop       (pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign rsp_valid = !fifo_empty;

    always_comb begin
        rsp_addr  = '0;
        rsp_instr = NOP_WORD;
        rsp_err   = 1'b0;
        if (!fifo_empty) begin
            {rsp_addr, rsp_instr, rsp_err} = fifo_head;
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: directed fetch scenarios and a random handshake
// soak, checked by an in-order scoreboard of hand-computed responses.
module tb_imem_responder;

    localparam int ADDR_W  = 32;
    localparam int DEPTH   = 256;
    localparam int LATENCY = 2;
    localparam int FIFO_D  = LATENCY + 1;

    logic        CLK       = 1'b0;
    logic        RESET     = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr  = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_instr;
    logic [31:0] rsp_addr;
    logic        rsp_err;
    logic        ld_we     = 1'b0;
    logic [7:0]  ld_addr   = '0;
    logic [31:0] ld_data   = '0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic        err;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;
    logic [31:0] cur_instr = '0;
    logic        cur_err   = 1'b0;
    bit          cur_lat   = 1'b0;
    bit          accepted  = 1'b0;
    bit          occ_chk   = 1'b0;

    logic [31:0] w    [4];
    logic [31:0] radr [6];
    logic [31:0] rins [6];
    logic        rerr [6];

    imem_responder #(
        .ADDR_W  (ADDR_W),
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_instr (rsp_instr),
        .rsp_addr  (rsp_addr),
        .rsp_err   (rsp_err),
        .ld_we     (ld_we),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, expv);
        end
    endtask

    // One clock: handshakes are judged mid-cycle, inputs change just after the edge.
    task automatic step();
        exp_t e;
        @(negedge CLK);
        accepted = req_valid && req_ready;
        if (accepted) begin
            e.addr  = req_addr;
            e.instr = cur_instr;
            e.err   = cur_err;
            e.acc   = cyc + 1;
            e.lat   = cur_lat;
            sb.push_back(e);
        end
        @(posedge CLK);
        #1;
        if (occ_chk) chk("occupancy_bound", 64'(sb.size() <= FIFO_D), 64'd1);
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (!RESET && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_rsp: got addr %h instr %h, want no response", rsp_addr, rsp_instr);
            end else begin
                e = sb.pop_front();
                chk("rsp_addr_instr", {rsp_addr, rsp_instr}, {e.addr, e.instr});
                chk("rsp_err", 64'(rsp_err), 64'(e.err));
                if (e.lat) chk("rsp_latency", 64'(cyc - e.acc), 64'(LATENCY));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time %0t reached, limit 200000", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] snap;
        logic [31:0] ra [3];
        int          n_acc;
        int          k;
        int          sel;

        w[0] = 32'h2008_0005; w[1] = 32'h2009_0003; w[2] = 32'h0109_5020; w[3] = 32'h0000_000C;
        radr[0] = 32'h0;   rins[0] = 32'h2008_0005; rerr[0] = 1'b0;
        radr[1] = 32'h4;   rins[1] = 32'hDEAD_BEEF; rerr[1] = 1'b0;
        radr[2] = 32'h8;   rins[2] = 32'h0109_5020; rerr[2] = 1'b0;
        radr[3] = 32'hC;   rins[3] = 32'h0000_000C; rerr[3] = 1'b0;
        radr[4] = 32'h6;   rins[4] = 32'h0;         rerr[4] = 1'b1;
        radr[5] = 32'h400; rins[5] = 32'h0;         rerr[5] = 1'b1;
        ra[0] = 32'h0; ra[1] = 32'h8; ra[2] = 32'hC;

        #2;
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_rsp_instr", 64'(rsp_instr), 64'd0);
        chk("reset_rsp_addr", 64'(rsp_addr), 64'd0);
        chk("reset_rsp_err", 64'(rsp_err), 64'd0);
        @(negedge CLK);
        RESET = 1'b0;
        @(posedge CLK);
        #1;
        chk("ready_after_reset", 64'(req_ready), 64'd1);

        for (int i = 0; i < 4; i++) begin
            ld_we = 1'b1; ld_addr = 8'(i); ld_data = w[i];
            step();
        end
        ld_we = 1'b0;

        // Back-to-back stream at full rate.
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1; req_addr = 32'(4 * i);
            cur_instr = w[i]; cur_err = 1'b0; cur_lat = 1'b1;
            step();
            chk("stream_accept", 64'(accepted), 64'd1);
        end
        req_valid = 1'b0; cur_lat = 1'b0;
        repeat (6) step();

        // Misaligned and out-of-range fetches.
        req_valid = 1'b1; req_addr = 32'h6; cur_instr = 32'h0; cur_err = 1'b1;
        step();
        req_addr = 32'h400;
        step();
        req_valid = 1'b0;
        repeat (5) step();

        // Backpressure: only FIFO_D requests fit while the consumer stalls.
        rsp_ready = 1'b0; n_acc = 0; k = 0; snap = '0;
        for (int i = 0; i < 8; i++) begin
            req_valid = 1'b1; req_addr = 32'(4 * k);
            cur_instr = w[k]; cur_err = 1'b0; cur_lat = 1'b0;
            step();
            if (accepted) begin
                n_acc++;
                if (k < 3) k++;
            end
            if (i == 3) snap = rsp_instr;
        end
        req_valid = 1'b0;
        chk("bp_accept_count", 64'(n_acc), 64'd3);
        chk("bp_ready_low", 64'(req_ready), 64'd0);
        chk("bp_head_held", 64'(rsp_instr), 64'(snap));
        chk("bp_head_value", {31'd0, rsp_valid, rsp_instr}, {31'd0, 1'b1, 32'h2008_0005});
        rsp_ready = 1'b1;
        repeat (5) step();
        chk("bp_ready_restored", 64'(req_ready), 64'd1);
        chk("bp_drained", 64'(sb.size()), 64'd0);

        // Loader write and fetch of the same word on one edge.
        ld_we = 1'b1; ld_addr = 8'd1; ld_data = 32'hDEAD_BEEF;
        req_valid = 1'b1; req_addr = 32'h4; cur_instr = 32'h2009_0003; cur_err = 1'b0; cur_lat = 1'b1;
        step();
        ld_we = 1'b0;
        cur_instr = 32'hDEAD_BEEF;
        step();
        req_valid = 1'b0; cur_lat = 1'b0;
        repeat (5) step();

        // Asynchronous reset with two in flight and one queued.
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1; req_addr = ra[i];
            cur_instr = w[ra[i][3:2]]; cur_err = 1'b0;
            step();
        end
        req_valid = 1'b0;
        chk("pre_reset_queued", 64'(rsp_valid), 64'd1);
        #2;
        RESET = 1'b1;
        #1;
        chk("reset_async_valid", 64'(rsp_valid), 64'd0);
        chk("reset_async_instr", 64'(rsp_instr), 64'd0);
        sb.delete();
        @(posedge CLK);
        #3;
        RESET = 1'b0;
        @(posedge CLK);
        #1;
        rsp_ready = 1'b1;
        repeat (4) step();
        chk("no_stale_rsp", 64'(rsp_valid), 64'd0);
        req_valid = 1'b1; req_addr = 32'h8; cur_instr = 32'h0109_5020; cur_err = 1'b0; cur_lat = 1'b1;
        step();
        req_valid = 1'b0; cur_lat = 1'b0;
        repeat (4) step();
        chk("post_reset_drained", 64'(sb.size()), 64'd0);

        // Random request/consumer handshakes.
        occ_chk = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            sel       = $urandom_range(0, 5);
            req_valid = ($urandom_range(0, 1) == 1);
            req_addr  = radr[sel];
            cur_instr = rins[sel];
            cur_err   = rerr[sel];
            cur_lat   = 1'b0;
            rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        occ_chk = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 20 && sb.size() > 0; i++) step();
        chk("final_drain", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-memory responder: the consumer end of the program-counter fetch interface.
- Accepts fetch addresses from the PC/fetch side and returns the 32-bit instruction word after a fixed pipeline latency.
- Ready/valid on both sides; response-side backpressure absorbed by an internal response FIFO.
- Contents loaded through a separate write port (testbench/boot loader). Sits between PC logic and the decode stage.

Parameters:
- ADDR_W, 32, fetch address width (byte address).
- DEPTH, 256, memory size in 32-bit words; power of two, ≥ 4.
- LATENCY, 2, request-accept to response-available cycles; legal range 1..4.
- NOP_WORD, 32'h0000_0000, instruction returned on error.

Ports:
- CLK  in  1  single clock, all state on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- req_valid  in  1  fetch request present.
- req_ready  out  1  responder can accept a request this cycle.
- req_addr  in  ADDR_W  fetch byte address (PC value).
- rsp_valid  out  1  response word available.
- rsp_ready  in  1  consumer takes response this cycle.
- rsp_instr  out  32  instruction word.
- rsp_addr  out  ADDR_W  address the response belongs to.
- rsp_err  out  1  request was misaligned or out of range.
- ld_we  in  1  loader write enable.
- ld_addr  in  $clog2(DEPTH)  loader word index.
- ld_data  in  32  loader write data.

Behaviour:
- Reset values:
  - Pipeline valid bits cleared.
  - FIFO empty; rsp_valid=0; rsp_instr=NOP_WORD; rsp_addr=0; rsp_err=0.
  - req_ready=1 once RESET deasserts.
  - Memory array not reset.
- Reset mid-operation: in-flight and queued responses are discarded, not delivered.
- Accept: request is taken on a rising edge with req_valid && req_ready. Memory is read at that edge.
- Index and error rules:
  - word index = req_addr[ADDR_W-1:2].
  - err if req_addr[1:0] != 0, or if index ≥ DEPTH.
  - On err: instr = NOP_WORD, err = 1, no memory access.
- Latency: a request accepted at edge N has rsp_valid=1 after edge N+LATENCY, provided nothing older is queued.
- Pipeline: LATENCY-stage shift of {valid, addr, instr, err} feeding a FIFO of depth LATENCY+1 (FIFO_D).
- Ordering: responses are in strict request order.
- Flow control:
  - occupancy = in-flight pipeline entries + FIFO count.
  - req_ready = (occupancy < FIFO_D), or (occupancy == FIFO_D and a FIFO pop occurs this cycle).
  - With rsp_ready held 1, throughput is 1 request/cycle.
  - FIFO never overflows.
- Output:
  - rsp_* show the FIFO head, registered.
  - Pop on rsp_valid && rsp_ready.
  - rsp_* stable while rsp_valid && !rsp_ready.
- Simultaneous push and pop on the FIFO: allowed at any occupancy, including full and empty. If empty, the entry passes to the head on the next cycle, not the same cycle.
- Loader:
  - ld_we writes mem[ld_addr] at the rising edge.
  - A fetch accepted on the same edge to the same word returns the OLD word.
  - The loader has priority over nothing; no stall.
- FIFO pointers wrap modulo FIFO_D. Count width is sufficient for FIFO_D.
- rsp_addr echoes the full req_addr, including misaligned low bits.

Decomposition:
- Shared package mips_pkg:
  - WORD_W=32.
  - NOP_WORD constant.
  - Fetch response struct {addr, instr, err}, also used by the decode stage.
- One sub-module: imem_rsp_fifo, a parameterised synchronous FIFO (width, depth) with async active-high reset and simultaneous push/pop.
- Memory array and pipeline stay in imem_responder.

Test Plan:
- Load mem[0..3] = 32'h2008_0005, 32'h2009_0003, 32'h0109_5020, 32'h0000_000C. Stream addrs 0,4,8,12 with rsp_ready=1, LATENCY=2 → responses at cycles 2..5, in order, err=0, correct words, req_ready stays 1.
- req_addr=32'h0000_0006 → rsp_instr=0, rsp_err=1, rsp_addr=32'h6. Addr 4*DEPTH=32'h400 → err=1.
- rsp_ready=0; issue requests until req_ready drops → exactly FIFO_D=3 accepted, rsp_* held constant. Raise rsp_ready → 3 in-order responses, then req_ready=1.
- Same edge: ld_we to word 1 (new 32'hDEAD_BEEF) and fetch of addr 4 → old 32'h2009_0003 returned. Next fetch of addr 4 → 32'hDEAD_BEEF.
- Assert RESET asynchronously (mid-clock) with 2 in flight and 1 queued → rsp_valid falls immediately, no stale response after release, and the first new request responds after LATENCY cycles.
- Random req_valid/rsp_ready toggling over 1000 cycles with a scoreboard → no loss, duplication or reorder; occupancy ≤ FIFO_D.
